goose_sprite_engine: RTL and testbench



---
 rtl/goose_sprite_engine_if.sv | 32 +++
 rtl/goose_sprite_engine.sv | 222 ++++++++++++++++++++++
 tb/tb_goose_sprite_engine.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/goose_sprite_engine_if.sv
// Pixel-side bundle between the VGA timing front end and the sprite engine.
// The timing/control side is the master; the sprite engine is the slave.
interface goose_sprite_engine_if #(
   parameter int LX_W  = 5,
   parameter int LY_W  = 5,
   parameter int IDX_W = 2
);
   logic [9:0]       hpos;
   logic [9:0]       vpos;
   logic             frame_start;
   logic             anim_en;
   logic [1:0]       mode;
   logic             restart;
   logic             move_en;
   logic [LX_W-1:0]  lut_x;
   logic [LY_W-1:0]  lut_y;
   logic             in_sprite;
   logic [IDX_W-1:0] frame_idx;
   logic             done;
   logic [9:0]       pos_x;
   logic [9:0]       pos_y;

   modport master (
      output hpos, vpos, frame_start, anim_en, mode, restart, move_en,
      input  lut_x, lut_y, in_sprite, frame_idx, done, pos_x, pos_y
   );

   modport slave (
      input  hpos, vpos, frame_start, anim_en, mode, restart, move_en,
      output lut_x, lut_y, in_sprite, frame_idx, done, pos_x, pos_y
   );
endinterface

// File: rtl/goose_sprite_engine.sv
// Animation sequencer, bouncing motion and registered hit/LUT-coordinate path
// for one LUT-based sprite on a 640x480 raster.
module goose_sprite_engine #(
   parameter int NUM_FRAMES = 4,
   parameter int FRAME_HOLD = 8,
   parameter int SPR_W      = 32,
   parameter int SPR_H      = 32,
   parameter int SCALE      = 3,
   parameter int H_RES      = 640,
   parameter int V_RES      = 480,
   parameter int X0         = 256,
   parameter int Y0         = 50
) (
   input  logic                   clk,
   input  logic                   reset,
   goose_sprite_engine_if.slave   bus
);

   localparam int IDX_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
   localparam int LX_W  = $clog2(SPR_W);
   localparam int LY_W  = $clog2(SPR_H);
   localparam int SW    = SPR_W << SCALE;
   localparam int SH    = SPR_H << SCALE;

   localparam logic [9:0]       X_MAX     = 10'(H_RES - SW);
   localparam logic [9:0]       Y_MAX     = 10'(V_RES - SH);
   localparam logic [10:0]      SW_LIM    = 11'(SW);
   localparam logic [10:0]      SH_LIM    = 11'(SH);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_FRAMES - 1);
   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
   localparam logic [7:0]       HOLD_LAST = 8'(FRAME_HOLD - 1);

   typedef enum logic [1:0] {
      MODE_LOOP    = 2'b00,
      MODE_PING    = 2'b01,
      MODE_ONESHOT = 2'b10,
      MODE_HOLD    = 2'b11
   } mode_e;

   // Shared by the ping-pong direction and both velocity signs: UP means +1.
   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   mode_e mode;
   assign mode = mode_e'(bus.mode);

   logic [IDX_W-1:0] idx_q,   idx_d;
   logic [7:0]       hold_q,  hold_d;
   dir_e             dir_q,   dir_d;
   logic             done_q,  done_d;
   logic [9:0]       pos_x_q, pos_x_d;
   logic [9:0]       pos_y_q, pos_y_d;
   dir_e             vel_x_q, vel_x_d;
   dir_e             vel_y_q, vel_y_d;
   logic [LX_W-1:0]  lut_x_q, lut_x_d;
   logic [LY_W-1:0]  lut_y_q, lut_y_d;
   logic             in_sprite_q, in_sprite_d;
   logic             advance;

   // Hit path: wrapped offsets from the sprite origin, clipped on both sides.
   logic [9:0] rel_x, rel_y;
   assign rel_x = bus.hpos - pos_x_q;
   assign rel_y = bus.vpos - pos_y_q;

   always_comb begin
      in_sprite_d = (bus.hpos >= pos_x_q) && ({1'b0, rel_x} < SW_LIM) &&
                    (bus.vpos >= pos_y_q) && ({1'b0, rel_y} < SH_LIM);
      lut_x_d     = LX_W'(rel_x >> SCALE);
      lut_y_d     = LY_W'(rel_y >> SCALE);
   end

   // NOTE: every variable gets a default before any branch so no path leaves
   // it unassigned; otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      idx_d   = idx_q;
      hold_d  = hold_q;
      dir_d   = dir_q;
      done_d  = done_q;
      advance = 1'b0;

      if (mode != MODE_ONESHOT) begin
         done_d = 1'b0;
      end

      if (bus.restart) begin
         idx_d  = '0;
         hold_d = '0;
         dir_d  = DIR_UP;
         done_d = 1'b0;
      end else if (bus.frame_start && bus.anim_en && mode != MODE_HOLD) begin
         if (hold_q == HOLD_LAST) begin
            hold_d  = '0;
            advance = 1'b1;
         end else begin
            hold_d  = hold_q + 8'd1;
         end
      end

      if (advance) begin
         case (mode)
            MODE_LOOP: begin
               idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
            end
            MODE_PING: begin
               // A single frame has nowhere to bounce to; stay on frame 0.
               if (NUM_FRAMES > 1) begin
                  if (dir_q == DIR_UP) begin
                     if (idx_q == IDX_LAST) begin
                        dir_d = DIR_DOWN;
                        idx_d = idx_q - IDX_ONE;
                     end else begin
                        idx_d = idx_q + IDX_ONE;
                     end
                  end else begin
                     if (idx_q == '0) begin
                        dir_d = DIR_UP;
                        idx_d = idx_q + IDX_ONE;
                     end else begin
                        idx_d = idx_q - IDX_ONE;
                     end
                  end
               end
            end
            MODE_ONESHOT: begin
               if (idx_q == IDX_LAST) begin
                  done_d = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_ONE;
                  if (idx_q == IDX_LAST - IDX_ONE) begin
                     done_d = 1'b1;
                  end
               end
            end
            MODE_HOLD: begin
            end
         endcase
      end
   end

   // Motion: one pixel per frame, clamped onto the edge when it reverses.
   always_comb begin
      pos_x_d = pos_x_q;
      pos_y_d = pos_y_q;
      vel_x_d = vel_x_q;
      vel_y_d = vel_y_q;

      if (bus.frame_start && bus.move_en) begin
         if (vel_x_q == DIR_UP) begin
            if (pos_x_q >= X_MAX - 10'd1) begin
               pos_x_d = X_MAX;
               vel_x_d = DIR_DOWN;
            end else begin
               pos_x_d = pos_x_q + 10'd1;
            end
         end else begin
            if (pos_x_q <= 10'd1) begin
               pos_x_d = '0;
               vel_x_d = DIR_UP;
            end else begin
               pos_x_d = pos_x_q - 10'd1;
            end
         end

         if (vel_y_q == DIR_UP) begin
            if (pos_y_q >= Y_MAX - 10'd1) begin
               pos_y_d = Y_MAX;
               vel_y_d = DIR_DOWN;
            end else begin
               pos_y_d = pos_y_q + 10'd1;
            end
         end else begin
            if (pos_y_q <= 10'd1) begin
               pos_y_d = '0;
               vel_y_d = DIR_UP;
            end else begin
               pos_y_d = pos_y_q - 10'd1;
            end
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q       <= '0;
         hold_q      <= '0;
         dir_q       <= DIR_UP;
         done_q      <= 1'b0;
         pos_x_q     <= 10'(X0);
         pos_y_q     <= 10'(Y0);
         vel_x_q     <= DIR_UP;
         vel_y_q     <= DIR_UP;
         lut_x_q     <= '0;
         lut_y_q     <= '0;
         in_sprite_q <= 1'b0;
      end else begin
         idx_q       <= idx_d;
         hold_q      <= hold_d;
         dir_q       <= dir_d;
         done_q      <= done_d;
         pos_x_q     <= pos_x_d;
         pos_y_q     <= pos_y_d;
         vel_x_q     <= vel_x_d;
         vel_y_q     <= vel_y_d;
         lut_x_q     <= lut_x_d;
         lut_y_q     <= lut_y_d;
         in_sprite_q <= in_sprite_d;
      end
   end

   assign bus.lut_x     = lut_x_q;
   assign bus.lut_y     = lut_y_q;
   assign bus.in_sprite = in_sprite_q;
   assign bus.frame_idx = idx_q;
   assign bus.done      = done_q;
   assign bus.pos_x     = pos_x_q;
   assign bus.pos_y     = pos_y_q;

endmodule

// File: tb/tb_goose_sprite_engine.sv
// Self-checking bench for goose_sprite_engine: a behavioural model feeds
// scoreboard queues of expected state and hit-path results.
module tb_goose_sprite_engine;

   localparam int NF    = 4;
   localparam int FH    = 8;
   localparam int SW    = 256;
   localparam int SH    = 256;
   localparam int X_MAX = 640 - SW;
   localparam int Y_MAX = 480 - SH;

   typedef struct packed {
      logic [1:0] idx;
      logic       done;
      logic [9:0] px;
      logic [9:0] py;
   } state_t;

   typedef struct packed {
      logic       hit;
      logic [4:0] lx;
      logic [4:0] ly;
   } hit_t;

   typedef struct {
      int   h;
      int   v;
      hit_t exp;
   } hit_vec_t;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   state_t state_q[$];
   hit_t   hit_q[$];

   // Behavioural model of the engine's architectural state.
   int m_idx, m_hold, m_done, m_px, m_py;
   bit m_dir_up, m_vx_up, m_vy_up;

   always #5 clk = ~clk;

   goose_sprite_engine_if #(.LX_W(5), .LY_W(5), .IDX_W(2)) bus ();

   goose_sprite_engine #(
      .NUM_FRAMES(NF), .FRAME_HOLD(FH), .SPR_W(32), .SPR_H(32), .SCALE(3),
      .H_RES(640), .V_RES(480), .X0(256), .Y0(50)
   ) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic model_reset();
      m_idx = 0; m_hold = 0; m_done = 0; m_dir_up = 1;
      m_px = 256; m_py = 50; m_vx_up = 1; m_vy_up = 1;
   endtask

   task automatic model_advance();
      case (bus.mode)
         2'b00: m_idx = (m_idx + 1) % NF;
         2'b01: begin
            if (NF > 1) begin
               if (m_dir_up && m_idx == NF - 1) m_dir_up = 0;
               else if (!m_dir_up && m_idx == 0) m_dir_up = 1;
               m_idx = m_dir_up ? m_idx + 1 : m_idx - 1;
            end
         end
         2'b10: begin
            if (m_idx < NF - 1) m_idx++;
            if (m_idx == NF - 1) m_done = 1;
         end
         default: ;
      endcase
   endtask

   task automatic model_step(input bit fs, input bit rs);
      if (bus.mode != 2'b10) m_done = 0;
      if (rs) begin
         m_idx = 0; m_hold = 0; m_dir_up = 1; m_done = 0;
      end else if (fs && bus.anim_en && bus.mode != 2'b11) begin
         if (m_hold == FH - 1) begin
            m_hold = 0;
            model_advance();
         end else begin
            m_hold++;
         end
      end
      if (fs && bus.move_en) begin
         if (m_vx_up) begin
            if (m_px + 1 >= X_MAX) begin m_px = X_MAX; m_vx_up = 0; end
            else m_px++;
         end else begin
            if (m_px - 1 <= 0) begin m_px = 0; m_vx_up = 1; end
            else m_px--;
         end
         if (m_vy_up) begin
            if (m_py + 1 >= Y_MAX) begin m_py = Y_MAX; m_vy_up = 0; end
            else m_py++;
         end else begin
            if (m_py - 1 <= 0) begin m_py = 0; m_vy_up = 1; end
            else m_py--;
         end
      end
   endtask

   // One control cycle: drive, push the model's expectation, pop and compare.
   task automatic pulse(input string tag, input bit fs = 1'b1, input bit rs = 1'b0);
      state_t exp, got;
      @(negedge clk);
      bus.frame_start = fs;
      bus.restart     = rs;
      model_step(fs, rs);
      exp = '{idx: 2'(m_idx), done: 1'(m_done), px: 10'(m_px), py: 10'(m_py)};
      state_q.push_back(exp);
      @(negedge clk);
      bus.frame_start = 1'b0;
      bus.restart     = 1'b0;
      got = '{idx: bus.frame_idx, done: bus.done, px: bus.pos_x, py: bus.pos_y};
      checks++;
      if (state_q.size() == 0) begin
         errors++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         exp = state_q.pop_front();
         if (got !== exp) begin
            errors++;
            $display("FAIL %s: got idx=%0d done=%0d x=%0d y=%0d, want idx=%0d done=%0d x=%0d y=%0d",
                     tag, got.idx, got.done, got.px, got.py, exp.idx, exp.done, exp.px, exp.py);
         end
      end
   endtask

   function automatic hit_t model_hit(input int h, input int v);
      hit_t r;
      int rx, ry;
      rx = (h - m_px) & 1023;
      ry = (v - m_py) & 1023;
      r.hit = (h >= m_px) && (h < m_px + SW) && (v >= m_py) && (v < m_py + SH);
      r.lx  = 5'((rx >> 3) & 31);
      r.ly  = 5'((ry >> 3) & 31);
      return r;
   endfunction

   task automatic hit_drive(input string tag, input int h, input int v, input hit_t exp);
      hit_t got, want;
      @(negedge clk);
      if (hit_q.size() != 0) begin
         want = hit_q.pop_front();
         got  = '{hit: bus.in_sprite, lx: bus.lut_x, ly: bus.lut_y};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL %s: got in=%0d lx=%0d ly=%0d, want in=%0d lx=%0d ly=%0d",
                     tag, got.hit, got.lx, got.ly, want.hit, want.lx, want.ly);
         end
      end
      bus.hpos = 10'(h);
      bus.vpos = 10'(v);
      hit_q.push_back(exp);
   endtask

   task automatic hit_flush(input string tag);
      hit_t got, want;
      @(negedge clk);
      checks++;
      if (hit_q.size() != 1) begin
         errors++;
         $display("FAIL %s: scoreboard holds %0d entries, want 1", tag, hit_q.size());
         hit_q.delete();
      end else begin
         want = hit_q.pop_front();
         got  = '{hit: bus.in_sprite, lx: bus.lut_x, ly: bus.lut_y};
         if (got !== want) begin
            errors++;
            $display("FAIL %s: got in=%0d lx=%0d ly=%0d, want in=%0d lx=%0d ly=%0d",
                     tag, got.hit, got.lx, got.ly, want.hit, want.lx, want.ly);
         end
      end
   endtask

   task automatic check_idx(input string tag, input int want_idx, input int want_done);
      checks++;
      if (bus.frame_idx !== 2'(want_idx) || bus.done !== 1'(want_done)) begin
         errors++;
         $display("FAIL %s: frame_idx=%0d done=%0d, want frame_idx=%0d done=%0d",
                  tag, bus.frame_idx, bus.done, want_idx, want_done);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.hpos = '0; bus.vpos = '0; bus.frame_start = 1'b0; bus.anim_en = 1'b0;
      bus.mode = 2'b00; bus.restart = 1'b0; bus.move_en = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (bus.frame_idx !== 2'd0 || bus.done !== 1'b0 || bus.pos_x !== 10'd256 ||
          bus.pos_y !== 10'd50 || bus.lut_x !== 5'd0 || bus.lut_y !== 5'd0 ||
          bus.in_sprite !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: idx=%0d done=%0d x=%0d y=%0d lx=%0d ly=%0d in=%0d",
                  bus.frame_idx, bus.done, bus.pos_x, bus.pos_y, bus.lut_x, bus.lut_y, bus.in_sprite);
      end
      reset = 1'b0;
   endtask

   task automatic test_hit_reset_pos();
      hit_vec_t vecs[8];
      vecs[0] = '{256,  50, '{1'b1, 5'd0,  5'd0}};
      vecs[1] = '{511,  50, '{1'b1, 5'd31, 5'd0}};
      vecs[2] = '{512,  50, '{1'b0, 5'd0,  5'd0}};
      vecs[3] = '{255,  50, '{1'b0, 5'd31, 5'd0}};
      vecs[4] = '{300, 305, '{1'b1, 5'd5,  5'd31}};
      vecs[5] = '{300, 306, '{1'b0, 5'd5,  5'd0}};
      vecs[6] = '{400,  49, '{1'b0, 5'd18, 5'd31}};
      vecs[7] = '{263,  57, '{1'b1, 5'd0,  5'd0}};
      foreach (vecs[i]) hit_drive("hit_fixed", vecs[i].h, vecs[i].v, vecs[i].exp);
      hit_flush("hit_fixed");
   endtask

   task automatic test_loop();
      bus.mode = 2'b00; bus.anim_en = 1'b1;
      for (int p = 1; p <= 32; p++) begin
         pulse("loop");
         if (p == 7)  check_idx("loop_7th", 0, 0);
         if (p == 8)  check_idx("loop_8th", 1, 0);
         if (p == 32) check_idx("loop_32nd", 0, 0);
      end
   endtask

   task automatic test_pingpong();
      int seq[7] = '{1, 2, 3, 2, 1, 0, 1};
      pulse("pp_restart", 1'b0, 1'b1);
      bus.mode = 2'b01;
      for (int p = 1; p <= 56; p++) begin
         pulse("pingpong");
         if (p % 8 == 0) check_idx($sformatf("pingpong_%0d", p), seq[p / 8 - 1], 0);
      end
   endtask

   task automatic test_oneshot();
      bus.mode = 2'b10;
      pulse("os_restart", 1'b0, 1'b1);
      for (int p = 1; p <= 40; p++) begin
         pulse("oneshot");
         if (p == 23) check_idx("oneshot_23rd", 2, 0);
         if (p == 24) check_idx("oneshot_24th", 3, 1);
         if (p == 40) check_idx("oneshot_40th", 3, 1);
      end
      pulse("os_restart_clear", 1'b0, 1'b1);
      check_idx("oneshot_restart", 0, 0);
      repeat (24) pulse("oneshot_again");
      check_idx("oneshot_again", 3, 1);
      bus.mode = 2'b00;
      pulse("os_mode_leave", 1'b0, 1'b0);
      check_idx("oneshot_mode_leave", 3, 0);
   endtask

   task automatic test_restart_coincident();
      bus.mode = 2'b00;
      pulse("rc_restart", 1'b0, 1'b1);
      repeat (7) pulse("rc_pre");
      pulse("rc_coincident", 1'b1, 1'b1);
      check_idx("restart_coincident", 0, 0);
      repeat (7) pulse("rc_post");
      check_idx("restart_hold_cleared", 0, 0);
      pulse("rc_post");
      check_idx("restart_then_advance", 1, 0);
   endtask

   task automatic test_pause();
      pulse("pause_restart", 1'b0, 1'b1);
      repeat (7) pulse("pause_pre");
      bus.anim_en = 1'b0;
      repeat (8) pulse("pause_anim_off");
      check_idx("pause_anim_off", 0, 0);
      bus.anim_en = 1'b1; bus.mode = 2'b11;
      repeat (8) pulse("pause_mode_hold");
      check_idx("pause_mode_hold", 0, 0);
      bus.mode = 2'b00;
      pulse("pause_resume");
      check_idx("pause_resume_keeps_hold", 1, 0);
   endtask

   task automatic test_motion();
      bus.move_en = 1'b1;
      for (int p = 1; p <= 520; p++) begin
         pulse("motion");
         case (p)
            128: begin checks++; if (bus.pos_x !== 10'd384) begin errors++; $display("FAIL bounce_x_right: pos_x=%0d want 384", bus.pos_x); end end
            129: begin checks++; if (bus.pos_x !== 10'd383) begin errors++; $display("FAIL bounce_x_back: pos_x=%0d want 383", bus.pos_x); end end
            174: begin checks++; if (bus.pos_y !== 10'd224) begin errors++; $display("FAIL bounce_y_bottom: pos_y=%0d want 224", bus.pos_y); end end
            175: begin checks++; if (bus.pos_y !== 10'd223) begin errors++; $display("FAIL bounce_y_back: pos_y=%0d want 223", bus.pos_y); end end
            398: begin checks++; if (bus.pos_y !== 10'd0)   begin errors++; $display("FAIL bounce_y_top: pos_y=%0d want 0", bus.pos_y); end end
            399: begin checks++; if (bus.pos_y !== 10'd1)   begin errors++; $display("FAIL bounce_y_up: pos_y=%0d want 1", bus.pos_y); end end
            512: begin checks++; if (bus.pos_x !== 10'd0)   begin errors++; $display("FAIL bounce_x_left: pos_x=%0d want 0", bus.pos_x); end end
            513: begin checks++; if (bus.pos_x !== 10'd1)   begin errors++; $display("FAIL bounce_x_fwd: pos_x=%0d want 1", bus.pos_x); end end
            default: ;
         endcase
      end
      bus.move_en = 1'b0;
   endtask

   task automatic test_hit_random();
      int h, v;
      for (int i = 0; i < 40; i++) begin
         if (i % 4 == 0) begin
            h = m_px + SW - 1 + int'($urandom_range(0, 2)) - 1;
            v = m_py + int'($urandom_range(0, 2)) - 1;
         end else begin
            h = int'($urandom_range(0, 639));
            v = int'($urandom_range(0, 479));
         end
         if (h < 0) h = 0;
         if (v < 0) v = 0;
         hit_drive("hit_random", h, v, model_hit(h, v));
      end
      hit_flush("hit_random");
   endtask

   initial begin
      test_reset();
      test_hit_reset_pos();
      test_loop();
      test_pingpong();
      test_oneshot();
      test_restart_coincident();
      test_pause();
      test_motion();
      test_hit_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
